clock_set_controller: RTL and testbench

//   Sequences time-setting for the MM:SS BCD counter chain. In RUN it passes
//   the 1 Hz tick to the seconds counter. The mode button walks through the

---
 rtl/clock_set_controller.sv | 157 +++++++++++++++
 tb/tb_clock_set_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// Time-set sequencer for the MM:SS chain; tick passthrough is combinational, load/clear strobes one clk after the commit press.
// No backpressure: buttons are levels and tick_in a pulse, all sampled every clk.
module clock_set_controller #(
    parameter logic [31:0] BLINK_DIV    = 32'd12_500_000,
    parameter logic [31:0] REPEAT_DELAY = 32'd25_000_000,
    parameter logic [31:0] REPEAT_RATE  = 32'd5_000_000,
    parameter logic [31:0] TIMEOUT_S    = 32'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [7:0] cur_min,
    output logic       tick_out,
    output logic [7:0] load_min,
    output logic       load_we,
    output logic       sec_clr,
    output logic [3:0] blank,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_MT = 2'd1,
        SET_MO = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  edit_q, edit_d;
    logic [7:0]  load_min_q, load_min_d;
    logic        mode_q, mode_d, inc_q, inc_d;
    logic [31:0] hold_q, hold_d;
    logic        rpt_phase_q, rpt_phase_d;
    logic [31:0] idle_q, idle_d;
    logic [31:0] blink_q, blink_d;
    logic        phase_q, phase_d;

    logic mode_e, inc_e, in_set, rpt_fire, inc_fire, timeout;

    // Digits above 9 (copied raw from cur_min) fold back to 0 like 9 does.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    always_comb begin
        mode_d   = mode_btn;
        inc_d    = inc_btn;
        mode_e   = mode_btn & ~mode_q;
        inc_e    = inc_btn & ~inc_q;
        in_set   = (state_q == SET_MT) || (state_q == SET_MO);

        // hold_q counts held cycles; first compare target is the delay, then the rate.
        hold_d      = '0;
        rpt_phase_d = 1'b0;
        rpt_fire    = 1'b0;
        if (in_set && inc_btn) begin
            if (inc_e) begin
                hold_d = 32'd1;
            end else if (hold_q + 32'd1 == (rpt_phase_q ? REPEAT_RATE : REPEAT_DELAY)) begin
                rpt_fire    = 1'b1;
                rpt_phase_d = 1'b1;
            end else begin
                hold_d      = hold_q + 32'd1;
                rpt_phase_d = rpt_phase_q;
            end
        end
        inc_fire = in_set & (inc_e | rpt_fire) & ~mode_e;

        idle_d  = idle_q;
        timeout = 1'b0;
        if (!in_set || mode_e || inc_e) begin
            idle_d = '0;
        end else if (tick_in) begin
            idle_d  = idle_q + 32'd1;
            timeout = (idle_q + 32'd1 >= TIMEOUT_S);
        end

        state_d    = state_q;
        edit_d     = edit_q;
        load_min_d = load_min_q;
        case (state_q)
            RUN: begin
                if (mode_e) begin
                    edit_d  = cur_min;
                    state_d = SET_MT;
                end
            end
            SET_MT: begin
                if (mode_e)        state_d = SET_MO;
                else if (timeout)  state_d = RUN;
                else if (inc_fire) edit_d[7:4] = bcd_inc(edit_q[7:4]);
            end
            SET_MO: begin
                if (mode_e) begin
                    state_d    = COMMIT;
                    load_min_d = edit_q;
                end else if (timeout) begin
                    state_d = RUN;
                end else if (inc_fire) begin
                    edit_d[3:0] = bcd_inc(edit_q[3:0]);
                end
            end
            default: state_d = RUN;
        endcase

        blink_d = blink_q;
        phase_d = phase_q;
        if (in_set) begin
            if (blink_q == BLINK_DIV - 32'd1) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 32'd1;
            end
        end
        if (inc_fire) phase_d = 1'b0;
        // Each newly entered edit digit starts visible with a fresh half-period.
        if (state_d != state_q && (state_d == SET_MT || state_d == SET_MO)) begin
            blink_d = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            edit_q      <= '0;
            load_min_q  <= '0;
            mode_q      <= 1'b1;
            inc_q       <= 1'b1;
            hold_q      <= '0;
            rpt_phase_q <= 1'b0;
            idle_q      <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_q      <= edit_d;
            load_min_q  <= load_min_d;
            mode_q      <= mode_d;
            inc_q       <= inc_d;
            hold_q      <= hold_d;
            rpt_phase_q <= rpt_phase_d;
            idle_q      <= idle_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
        end
    end

    assign tick_out = tick_in & (state_q == RUN);
    assign load_we  = (state_q == COMMIT);
    assign sec_clr  = (state_q == COMMIT);
    assign load_min = load_min_q;
    assign blank    = {phase_q & (state_q == SET_MT), phase_q & (state_q == SET_MO), 2'b00};
    assign state    = state_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: fixed vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_clock_set_controller;
    localparam int BD = 4;
    localparam int RD = 8;
    localparam int RR = 3;
    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       reset, tick_in, mode_btn, inc_btn;
    logic [7:0] cur_min;
    logic       tick_out, load_we, sec_clr;
    logic [7:0] load_min;
    logic [3:0] blank;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clock_set_controller #(
        .BLINK_DIV(BD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_S(TO)
    ) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .mode_btn(mode_btn),
        .inc_btn(inc_btn), .cur_min(cur_min), .tick_out(tick_out),
        .load_min(load_min), .load_we(load_we), .sec_clr(sec_clr),
        .blank(blank), .state(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
    task automatic put(input logic m, input logic i, input logic t, input logic [7:0] c);
        mode_btn = m; inc_btn = i; tick_in = t; cur_min = c;
        #2;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic m, input logic i, input logic t, input logic [7:0] c);
        put(m, i, t, c);
        nxt();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       m, i, t;
        logic [7:0] c;
        logic [1:0] e_state;
        logic       e_tick, e_we, e_clr;
        logic [7:0] e_lm;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic m, input logic i, input logic t, input logic [7:0] c,
                                input logic [1:0] es, input logic et, input logic ew,
                                input logic ec, input logic [7:0] el);
        vec_t v;
        v.m = m; v.i = i; v.t = t; v.c = c;
        v.e_state = es; v.e_tick = et; v.e_we = ew; v.e_clr = ec; v.e_lm = el;
        return v;
    endfunction

    // Reference model: digits as integers, held-cycle count with modulo repeat rule.
    int         ms, mt, mo, mk_held, midle, mb;
    bit         mph, mp, ip;
    logic [7:0] mload;

    task automatic m_reset;
        ms = 0; mt = 0; mo = 0; mk_held = 0; midle = 0; mb = 0;
        mph = 0; mp = 1; ip = 1; mload = 8'h00;
    endtask

    function automatic logic [16:0] m_expect(input bit t);
        logic [3:0] b;
        b = {mph && ms == 1, mph && ms == 2, 2'b00};
        return {2'(ms), t && ms == 0, ms == 3, ms == 3, mload, b};
    endfunction

    task automatic m_step(input bit m, input bit i, input bit t, input logic [7:0] c);
        bit me, ie, set, rep, bump, tmo;
        int nst;
        me  = m && !mp;
        ie  = i && !ip;
        set = (ms == 1 || ms == 2);
        if (set && i) mk_held = ie ? 1 : mk_held + 1;
        else          mk_held = 0;
        rep  = set && i && !ie && (mk_held == RD || (mk_held > RD && (mk_held - RD) % RR == 0));
        bump = set && (ie || rep) && !me;
        tmo  = 0;
        if (!set || me || ie) midle = 0;
        else if (t) begin
            midle++;
            tmo = (midle >= TO);
        end
        nst = ms;
        case (ms)
            0: if (me) begin nst = 1; mt = int'(c[7:4]); mo = int'(c[3:0]); end
            1: if (me) nst = 2;
               else if (tmo) nst = 0;
               else if (bump) mt = (mt >= 9) ? 0 : mt + 1;
            2: if (me) begin nst = 3; mload = 8'(mt * 16 + mo); end
               else if (tmo) nst = 0;
               else if (bump) mo = (mo >= 9) ? 0 : mo + 1;
            default: nst = 0;
        endcase
        if (set) begin
            mb++;
            if (mb == BD) begin mb = 0; mph = !mph; end
        end
        if (bump) mph = 0;
        if ((nst == 1 || nst == 2) && nst != ms) begin mb = 0; mph = 0; end
        ms = nst; mp = m; ip = i;
    endtask

    initial begin
        logic [16:0] act_v;
        logic [3:0]  eb;
        bit          rm, ri, rt;
        logic [7:0]  rc;

        // Reset with mode held: releasing it must not start an edit.
        mode_btn = 1'b1; inc_btn = 1'b0; tick_in = 1'b0; cur_min = 8'h00;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            put(n < 3, 1'b0, 1'b0, 8'h00);
            check("held_reset_state", 32'(state), 32'd0);
            check("held_reset_we", 32'(load_we), 32'd0);
            check("held_reset_blank", 32'(blank), 32'd0);
            nxt();
        end

        // Vector table: 29 -> three tens incs, two ones incs -> commit 51.
        tbl[0]  = mk(1, 0, 1, 8'h29, 2'd0, 1, 0, 0, 8'h00);
        tbl[1]  = mk(0, 1, 1, 8'h29, 2'd1, 0, 0, 0, 8'h00);
        tbl[2]  = mk(0, 0, 1, 8'h29, 2'd1, 0, 0, 0, 8'h00);
        tbl[3]  = mk(0, 1, 1, 8'h29, 2'd1, 0, 0, 0, 8'h00);
        tbl[4]  = mk(0, 0, 1, 8'h29, 2'd1, 0, 0, 0, 8'h00);
        tbl[5]  = mk(0, 1, 1, 8'h29, 2'd1, 0, 0, 0, 8'h00);
        tbl[6]  = mk(0, 0, 1, 8'h29, 2'd1, 0, 0, 0, 8'h00);
        tbl[7]  = mk(1, 0, 1, 8'h29, 2'd1, 0, 0, 0, 8'h00);
        tbl[8]  = mk(0, 1, 1, 8'h29, 2'd2, 0, 0, 0, 8'h00);
        tbl[9]  = mk(0, 0, 1, 8'h29, 2'd2, 0, 0, 0, 8'h00);
        tbl[10] = mk(0, 1, 1, 8'h29, 2'd2, 0, 0, 0, 8'h00);
        tbl[11] = mk(0, 0, 1, 8'h29, 2'd2, 0, 0, 0, 8'h00);
        tbl[12] = mk(1, 0, 1, 8'h29, 2'd2, 0, 0, 0, 8'h00);
        tbl[13] = mk(0, 0, 1, 8'h29, 2'd3, 0, 1, 1, 8'h51);
        tbl[14] = mk(0, 0, 1, 8'h29, 2'd0, 1, 0, 0, 8'h51);
        tbl[15] = mk(0, 0, 0, 8'h29, 2'd0, 0, 0, 0, 8'h51);
        mode_btn = 1'b0;
        do_reset();
        cyc(0, 0, 0, 8'h29);
        for (int n = 0; n < 16; n++) begin
            put(tbl[n].m, tbl[n].i, tbl[n].t, tbl[n].c);
            check($sformatf("table_row%0d", n), {19'd0, state, tick_out, load_we, sec_clr, load_min},
                  {19'd0, tbl[n].e_state, tbl[n].e_tick, tbl[n].e_we, tbl[n].e_clr, tbl[n].e_lm});
            nxt();
        end

        // Blink in SET_MT toggles blank[3] every BD clocks.
        cyc(1, 0, 0, 8'h12);
        for (int n = 0; n < 16; n++) begin
            put(0, 0, 0, 8'h12);
            eb = (((n / BD) % 2) == 1) ? 4'b1000 : 4'b0000;
            check($sformatf("blink_mt_%0d", n), 32'(blank), 32'(eb));
            nxt();
        end
        cyc(1, 0, 0, 8'h12);
        put(0, 0, 0, 8'h12);
        check("blink_mo_enter", 32'(blank), 32'd0);
        check("blink_mo_state", 32'(state), 32'd2);
        nxt();
        cyc(1, 0, 0, 8'h12);
        cyc(0, 0, 0, 8'h12);
        put(0, 0, 0, 8'h12);
        check("blink_run_blank", 32'(blank), 32'd0);
        check("blink_run_state", 32'(state), 32'd0);
        nxt();

        // Ticks blocked in SET_MO, timeout after TO idle ticks without a load.
        cyc(1, 0, 0, 8'h07);
        cyc(0, 0, 0, 8'h07);
        cyc(1, 0, 0, 8'h07);
        cyc(0, 0, 0, 8'h07);
        for (int tk = 1; tk <= TO; tk++) begin
            put(0, 0, 1, 8'h07);
            check("timeout_tick_blocked", 32'(tick_out), 32'd0);
            check("timeout_no_we", 32'(load_we), 32'd0);
            nxt();
            put(0, 0, 0, 8'h07);
            check($sformatf("timeout_state_%0d", tk), 32'(state), (tk < TO) ? 32'd2 : 32'd0);
            check("timeout_no_clr", 32'(sec_clr), 32'd0);
            nxt();
        end

        // Auto-repeat: ones 0 held RD+2*RR clocks -> 4.
        cyc(1, 0, 0, 8'h30);
        cyc(0, 0, 0, 8'h30);
        cyc(1, 0, 0, 8'h30);
        cyc(0, 0, 0, 8'h30);
        for (int h = 0; h < RD + 2 * RR; h++) cyc(0, 1, 0, 8'h30);
        cyc(0, 0, 0, 8'h30);
        cyc(1, 0, 0, 8'h30);
        put(0, 0, 0, 8'h30);
        check("repeat_load_min", 32'(load_min), 32'h34);
        check("repeat_strobes", {30'd0, load_we, sec_clr}, 32'd3);
        nxt();

        // Mode and inc in the same clock: mode wins, tens unchanged.
        cyc(0, 0, 0, 8'h45);
        cyc(1, 0, 0, 8'h45);
        cyc(0, 0, 0, 8'h45);
        cyc(1, 1, 0, 8'h45);
        put(0, 0, 0, 8'h45);
        check("simul_state", 32'(state), 32'd2);
        nxt();
        cyc(1, 0, 0, 8'h45);
        put(0, 0, 0, 8'h45);
        check("simul_load_min", 32'(load_min), 32'h45);
        nxt();
        cyc(0, 0, 0, 8'h45);

        // Asynchronous reset in SET_MO.
        cyc(1, 0, 0, 8'h45);
        cyc(0, 0, 0, 8'h45);
        cyc(1, 0, 0, 8'h45);
        put(0, 0, 0, 8'h45);
        check("pre_reset_state", 32'(state), 32'd2);
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_lm", 32'(load_min), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            put(0, 0, 0, 8'h45);
            check("post_reset_strobes", {29'd0, state, load_we | sec_clr}, 32'd0);
            nxt();
        end

        // Randomized run against the reference model.
        put(0, 0, 0, 8'h00);
        do_reset();
        m_reset();
        rm = 0; ri = 0; rc = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) rm = !rm;
            if ($urandom_range(0, 99) < 9) ri = !ri;
            rt = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) rc = 8'($urandom_range(0, 255));
            put(rm, ri, rt, rc);
            act_v = {state, tick_out, load_we, sec_clr, load_min, blank};
            check($sformatf("random_cycle%0d", n), 32'(act_v), 32'(m_expect(rt)));
            m_step(rm, ri, rt, rc);
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
